// File: rtl/mac_pkg.sv
// mac_pkg
//   Shared definitions for the MAC register interface and the stream sequencer
//   that drives it: register addresses, CTRL bit positions, the sequencer state
//   encoding and a helper that assembles a CTRL word.
package mac_pkg;

    localparam logic [7:0] ADDR_INA    = 8'h24;
    localparam logic [7:0] ADDR_INB    = 8'h25;
    localparam logic [7:0] ADDR_ACC_LO = 8'h26;
    localparam logic [7:0] ADDR_ACC_HI = 8'h27;
    localparam logic [7:0] ADDR_OUT    = 8'h28;
    localparam logic [7:0] ADDR_CTRL   = 8'h29;

    // CTRL = {ON, SHIFT[2:0], MODE[1:0], START, I_MSK}
    localparam int CTRL_ON        = 7;
    localparam int CTRL_SHIFT_LSB = 4;
    localparam int CTRL_MODE_LSB  = 2;
    localparam int CTRL_START     = 1;
    localparam int CTRL_IMSK      = 0;

    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CLR,
        GO,
        WAIT,
        ABORT,
        READ_LO,
        READ_HI,
        READ_OUT,
        CAP,
        RESP
    } seq_state_e;

    function automatic logic [31:0] ctrl_word(input logic [2:0] shift,
                                              input logic [1:0] mode,
                                              input logic       start);
        logic [31:0] w;
        w                          = '0;
        w[CTRL_ON]                 = 1'b1;
        w[CTRL_SHIFT_LSB +: 3]     = shift;
        w[CTRL_MODE_LSB +: 2]      = mode;
        w[CTRL_START]              = start;
        w[CTRL_IMSK]               = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/mac_stream_sequencer.sv
// mac_stream_sequencer
//   Bus-master front end for the MAC register block. Accepts a dot-product
//   command, streams operand pairs into INA/INB, pulses START once per element,
//   waits for the MAC done interrupt, then reads ACC_LO/ACC_HI/OUT back and
//   returns a single result beat.
//
//   Ports
//     clk, reset                     clock, synchronous active-high reset
//     cmd_valid/cmd_ready            command handshake (len, mode, shift)
//     op_valid/op_ready, op_a/op_b   operand handshake, one pair per element
//     res_valid/res_ready            result handshake (res_acc, res_out, res_err)
//     mac_addr/mac_wdata/mac_we      register bus towards the MAC block
//     mac_rdata, mac_irq             registered read data and done interrupt
//     busy                           high whenever not idle
//
//   Every bus output is registered: the operation chosen in a state becomes
//   visible on the bus during the following cycle.
module mac_stream_sequencer
    import mac_pkg::*;
#(
    parameter int LEN_W    = 8,
    parameter int TIMEOUT  = 64,
    parameter int IRQ_HOLD = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [1:0]       cmd_mode,
    input  logic [2:0]       cmd_shift,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [39:0]      res_acc,
    output logic [15:0]      res_out,
    output logic             res_err,
    output logic [7:0]       mac_addr,
    output logic [31:0]      mac_wdata,
    output logic             mac_we,
    input  logic [31:0]      mac_rdata,
    input  logic             mac_irq,
    output logic             busy
);

    localparam int HOLD_W = (IRQ_HOLD < 1) ? 1 : $clog2(IRQ_HOLD + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    seq_state_e       state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [1:0]       mode_q, mode_d;
    logic [2:0]       shift_q, shift_d;
    logic [31:0]      opb_q, opb_d;
    logic [7:0]       addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             we_q, we_d;
    logic             res_valid_q, res_valid_d;
    logic [39:0]      acc_q, acc_d;
    logic [15:0]      out_q, out_d;
    logic             err_q, err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            hold_q      <= '0;
            tmo_q       <= '0;
            mode_q      <= '0;
            shift_q     <= '0;
            opb_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            res_valid_q <= 1'b0;
            acc_q       <= '0;
            out_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            hold_q      <= hold_d;
            tmo_q       <= tmo_d;
            mode_q      <= mode_d;
            shift_q     <= shift_d;
            opb_q       <= opb_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            res_valid_q <= res_valid_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        hold_d  = hold_q;
        tmo_d   = tmo_q;
        mode_d  = mode_q;
        shift_d = shift_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        out_d   = out_q;
        err_d   = err_q;
        // bus idles (address 0, no write) unless a state issues an operation
        addr_d  = '0;
        wdata_d = '0;
        we_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    rem_d   = cmd_len;
                    mode_d  = cmd_mode;
                    shift_d = cmd_shift;
                    err_d   = 1'b0;
                    if (cmd_mode == MODE_ILLEGAL) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        acc_d   = '0;
                        out_d   = '0;
                    end else if (cmd_len == '0) begin
                        state_d = READ_LO;
                        addr_d  = ADDR_ACC_LO;
                    end else begin
                        state_d = LOAD_A;
                    end
                end
            end
            LOAD_A: begin
                if (op_valid) begin
                    we_d    = 1'b1;
                    addr_d  = ADDR_INA;
                    wdata_d = op_a;
                    opb_d   = op_b;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                we_d    = 1'b1;
                addr_d  = ADDR_INB;
                wdata_d = opb_q;
                state_d = CLR;
            end
            CLR: begin
                // drop START so the next write produces a clean rising edge
                we_d    = 1'b1;
                addr_d  = ADDR_CTRL;
                wdata_d = ctrl_word(shift_q, mode_q, 1'b0);
                state_d = GO;
            end
            GO: begin
                we_d    = 1'b1;
                addr_d  = ADDR_CTRL;
                wdata_d = ctrl_word(shift_q, mode_q, 1'b1);
                hold_d  = HOLD_W'(IRQ_HOLD);
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // a level-high irq left over from the previous element is
                // masked until the hold counter has drained
                if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end
                if ((hold_q == '0) && mac_irq) begin
                    rem_d = (rem_q != '0) ? rem_q - LEN_W'(1) : rem_q;
                    if (rem_q <= LEN_W'(1)) begin
                        state_d = READ_LO;
                        addr_d  = ADDR_ACC_LO;
                    end else begin
                        state_d = LOAD_A;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d = ABORT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ABORT: begin
                we_d    = 1'b1;
                addr_d  = ADDR_CTRL;
                wdata_d = '0;
                err_d   = 1'b1;
                acc_d   = '0;
                out_d   = '0;
                state_d = RESP;
            end
            READ_LO: begin
                addr_d  = ADDR_ACC_HI;
                state_d = READ_HI;
            end
            READ_HI: begin
                acc_d[31:0] = mac_rdata;
                addr_d      = ADDR_OUT;
                state_d     = READ_OUT;
            end
            READ_OUT: begin
                acc_d[39:32] = mac_rdata[7:0];
                state_d      = CAP;
            end
            CAP: begin
                out_d   = mac_rdata[15:0];
                state_d = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        res_valid_d = (state_d == RESP);
    end

    assign cmd_ready = (state_q == IDLE);
    assign op_ready  = (state_q == LOAD_A);
    assign busy      = (state_q != IDLE);
    assign res_valid = res_valid_q;
    assign res_acc   = acc_q;
    assign res_out   = out_q;
    assign res_err   = err_q;
    assign mac_addr  = addr_q;
    assign mac_wdata = wdata_q;
    assign mac_we    = we_q;

endmodule

// File: tb/tb_mac_stream_sequencer.sv
// tb_mac_stream_sequencer
//   Directed bench for mac_stream_sequencer. Contains a small behavioural model
//   of the MAC register block (INA/INB/ACC/OUT/CTRL, done irq two cycles after
//   a START rising edge, OUT = ACC >> (16 - shift)) and a bus monitor.
module tb_mac_stream_sequencer;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_len;
    logic [1:0]  cmd_mode;
    logic [2:0]  cmd_shift;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        res_valid;
    logic        res_ready;
    logic [39:0] res_acc;
    logic [15:0] res_out;
    logic        res_err;
    logic [7:0]  mac_addr;
    logic [31:0] mac_wdata;
    logic        mac_we;
    logic [31:0] mac_rdata;
    logic        mac_irq;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mac_stream_sequencer #(.LEN_W(8), .TIMEOUT(64), .IRQ_HOLD(3)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_mode(cmd_mode), .cmd_shift(cmd_shift),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_acc(res_acc),
        .res_out(res_out), .res_err(res_err),
        .mac_addr(mac_addr), .mac_wdata(mac_wdata), .mac_we(mac_we),
        .mac_rdata(mac_rdata), .mac_irq(mac_irq), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- MAC register block model ----------------
    logic [31:0] m_ina, m_inb;
    logic [7:0]  m_ctrl;
    logic [39:0] m_acc, m_pend;
    logic [1:0]  m_cnt;
    logic        m_irq;
    logic        irq_kill;
    logic [39:0] m_shifted;

    assign m_shifted = m_acc >> (5'd16 - {2'b00, m_ctrl[6:4]});
    assign mac_irq   = m_irq & ~irq_kill;

    function automatic logic [39:0] mac_prod(input logic [1:0] mode,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [39:0] p;
        case (mode)
            2'b01:   p = {24'b0, a[15:0]} * {24'b0, b[15:0]};
            2'b10:   p = {24'b0, a[31:16]} * {24'b0, b[31:16]};
            default: p = {8'b0, a} * {8'b0, b};
        endcase
        return p;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_ina <= '0; m_inb <= '0; m_ctrl <= '0; m_acc <= '0; m_pend <= '0;
            m_cnt <= '0; m_irq <= 1'b0; mac_rdata <= '0;
        end else begin
            if (m_cnt != 2'd0) begin
                m_cnt <= m_cnt - 2'd1;
                if (m_cnt == 2'd1) begin
                    m_acc <= m_acc + m_pend;
                    m_irq <= 1'b1;
                end
            end
            if (mac_we) begin
                case (mac_addr)
                    8'h24: m_ina <= mac_wdata;
                    8'h25: m_inb <= mac_wdata;
                    8'h29: begin
                        m_ctrl <= mac_wdata[7:0];
                        if (mac_wdata[7] && mac_wdata[1] && !m_ctrl[1]) begin
                            m_cnt  <= 2'd2;
                            m_irq  <= 1'b0;
                            m_pend <= mac_prod(mac_wdata[3:2], m_ina, m_inb);
                        end
                    end
                    default: ;
                endcase
            end else begin
                case (mac_addr)
                    8'h24:   mac_rdata <= m_ina;
                    8'h25:   mac_rdata <= m_inb;
                    8'h26:   mac_rdata <= m_acc[31:0];
                    8'h27:   mac_rdata <= {24'b0, m_acc[39:32]};
                    8'h28:   mac_rdata <= {16'b0, m_shifted[15:0]};
                    8'h29:   mac_rdata <= {24'b0, m_ctrl};
                    default: mac_rdata <= '0;
                endcase
            end
        end
    end

    // ---------------- bus monitor ----------------
    int we_cnt = 0, ina_cnt = 0, inb_cnt = 0, ctrl0_cnt = 0, start_cnt = 0, beat_cnt = 0;
    logic [7:0] last_go = '0, last_clr = '0;

    always @(posedge clk) begin
        if (mac_we) begin
            we_cnt++;
            if (mac_addr == 8'h24) ina_cnt++;
            if (mac_addr == 8'h25) inb_cnt++;
            if (mac_addr == 8'h29) begin
                if (mac_wdata == 32'h0) ctrl0_cnt++;
                else if (mac_wdata[1]) begin start_cnt++; last_go = mac_wdata[7:0]; end
                else last_clr = mac_wdata[7:0];
            end
        end
        if (res_valid && res_ready) beat_cnt++;
    end

    // ---------------- drivers ----------------
    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] len, input logic [1:0] mode,
                            input logic [2:0] shift, output bit ok);
        int n;
        @(negedge clk);
        cmd_len = len; cmd_mode = mode; cmd_shift = shift; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        ok = cmd_ready;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // gap=0: valid raised at once (also while the sequencer is not ready);
    // gap>0: wait for ready, then hold valid low for gap cycles first
    task automatic send_op(input logic [31:0] a, input logic [31:0] b,
                           input int gap, output bit ok);
        int n;
        op_a = a; op_b = b;
        n = 0;
        if (gap > 0) begin
            while (!op_ready && n < 200) begin @(negedge clk); n++; end
            repeat (gap) @(negedge clk);
        end
        op_valid = 1'b1;
        while (!op_ready && n < 200) begin @(negedge clk); n++; end
        ok = op_ready;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic wait_res(input int limit, output bit ok, output logic [39:0] acc,
                            output logic [15:0] out, output logic err);
        int n;
        n = 0;
        while (!res_valid && n < limit) begin @(negedge clk); n++; end
        ok = res_valid; acc = res_acc; out = res_out; err = res_err;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        do_reset();
        total++;
        if ({cmd_ready, busy, res_valid, mac_we, res_err, op_ready} !== 6'b100000) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=100000",
                            {cmd_ready, busy, res_valid, mac_we, res_err, op_ready});
        end
        total++;
        if ({mac_addr, mac_wdata} !== 40'h0) begin
            bad++; $display("FAIL reset_bus got=%h/%h exp=0/0", mac_addr, mac_wdata);
        end
        total++;
        if ({res_acc, res_out} !== 56'h0) begin
            bad++; $display("FAIL reset_payload got=%h/%h exp=0/0", res_acc, res_out);
        end
    endtask

    task automatic test_single;
        bit ok1, ok2, ok3; logic [39:0] acc; logic [15:0] out; logic err;
        do_reset();
        send_cmd(8'd1, 2'b01, 3'd0, ok1);
        send_op(32'd3, 32'd5, 0, ok2);
        wait_res(100, ok3, acc, out, err);
        total++;
        if ({ok1, ok2, ok3} !== 3'b111) begin
            bad++; $display("FAIL single_handshake got=%b exp=111", {ok1, ok2, ok3});
        end
        total++;
        if ({acc, out, err} !== {40'd15, 16'd0, 1'b0}) begin
            bad++; $display("FAIL single_result got=%h/%h/%b exp=f/0/0", acc, out, err);
        end
        total++;
        if ({last_clr, last_go} !== 16'h8587) begin
            bad++; $display("FAIL single_ctrl got=%h/%h exp=85/87", last_clr, last_go);
        end
        total++;
        if (res_valid !== 1'b0) begin
            bad++; $display("FAIL single_res_drop got=%b exp=0", res_valid);
        end
    endtask

    task automatic test_cumulative;
        bit ok, okc, oko; logic [39:0] acc; logic [15:0] out; logic err; int b0;
        do_reset();
        b0 = beat_cnt;
        okc = 1'b1; oko = 1'b1;
        send_cmd(8'd3, 2'b01, 3'd0, ok); okc &= ok;
        send_op(32'd2, 32'd3, 0, ok); oko &= ok;
        send_op(32'd4, 32'd5, 0, ok); oko &= ok;
        send_op(32'h0000FFFF, 32'h0000FFFF, 0, ok); oko &= ok;
        wait_res(100, ok, acc, out, err);
        repeat (10) @(negedge clk);
        total++;
        if ({okc, oko, ok, acc, err} !== {3'b111, 40'h00FFFE001B, 1'b0}) begin
            bad++; $display("FAIL cumulative_acc got=%b%b%b/%h/%b exp=111/00fffe001b/0",
                            okc, oko, ok, acc, err);
        end
        total++;
        if (beat_cnt - b0 !== 1) begin
            bad++; $display("FAIL cumulative_beats got=%0d exp=1", beat_cnt - b0);
        end
    endtask

    task automatic test_hi_shift_and_len0;
        bit ok1, ok2, ok3; logic [39:0] acc; logic [15:0] out; logic err; int w0;
        do_reset();
        send_cmd(8'd1, 2'b10, 3'd7, ok1);
        send_op(32'h01000000, 32'h01000000, 0, ok2);
        wait_res(100, ok3, acc, out, err);
        total++;
        if ({ok1, ok2, ok3, acc, out, err} !== {3'b111, 40'h0000010000, 16'h0080, 1'b0}) begin
            bad++; $display("FAIL hi_shift got=%b%b%b/%h/%h/%b exp=111/10000/0080/0",
                            ok1, ok2, ok3, acc, out, err);
        end
        total++;
        if (last_go !== 8'hFB) begin
            bad++; $display("FAIL hi_shift_ctrl got=%h exp=fb", last_go);
        end
        // zero-length command: read back only, accumulator untouched
        w0 = we_cnt;
        send_cmd(8'd0, 2'b01, 3'd0, ok1);
        wait_res(50, ok3, acc, out, err);
        total++;
        if ({ok1, ok3, acc, out, err} !== {2'b11, 40'h0000010000, 16'h0080, 1'b0}) begin
            bad++; $display("FAIL len0 got=%b%b/%h/%h/%b exp=11/10000/0080/0",
                            ok1, ok3, acc, out, err);
        end
        total++;
        if (we_cnt - w0 !== 0) begin
            bad++; $display("FAIL len0_writes got=%0d exp=0", we_cnt - w0);
        end
    endtask

    task automatic test_illegal_mode;
        bit ok1, ok2; logic [39:0] acc; logic [15:0] out; logic err; int w0;
        w0 = we_cnt;
        send_cmd(8'd5, 2'b11, 3'd2, ok1);
        wait_res(50, ok2, acc, out, err);
        total++;
        if ({ok1, ok2, err, acc, out} !== {3'b111, 56'h0}) begin
            bad++; $display("FAIL illegal_mode got=%b%b/%b/%h/%h exp=11/1/0/0",
                            ok1, ok2, err, acc, out);
        end
        total++;
        if (we_cnt - w0 !== 0) begin
            bad++; $display("FAIL illegal_writes got=%0d exp=0", we_cnt - w0);
        end
    endtask

    task automatic test_timeout;
        bit ok1, ok2, ok3; logic [39:0] acc; logic [15:0] out; logic err; int c0;
        do_reset();
        irq_kill = 1'b1;
        c0 = ctrl0_cnt;
        send_cmd(8'd1, 2'b01, 3'd0, ok1);
        send_op(32'd9, 32'd9, 0, ok2);
        wait_res(200, ok3, acc, out, err);
        irq_kill = 1'b0;
        total++;
        if ({ok1, ok2, ok3, err, acc, out} !== {4'b1111, 56'h0}) begin
            bad++; $display("FAIL timeout_result got=%b%b%b/%b/%h/%h exp=111/1/0/0",
                            ok1, ok2, ok3, err, acc, out);
        end
        total++;
        if (ctrl0_cnt - c0 !== 1) begin
            bad++; $display("FAIL timeout_ctrl0 got=%0d exp=1", ctrl0_cnt - c0);
        end
    endtask

    task automatic test_back_to_back;
        bit ok, okc, oko; logic [39:0] acc; logic [15:0] out; logic err;
        int i0, j0, b0, n;
        do_reset();
        i0 = ina_cnt; j0 = inb_cnt; b0 = beat_cnt;
        okc = 1'b1; oko = 1'b1;
        send_cmd(8'd3, 2'b01, 3'd0, ok); okc &= ok;
        send_op(32'd1, 32'd2, 0, ok); oko &= ok;
        send_op(32'd3, 32'd4, 3, ok); oko &= ok;
        send_op(32'd5, 32'd6, 5, ok); oko &= ok;
        n = 0;
        while (!res_valid && n < 100) begin @(negedge clk); n++; end
        // sink stalls: payload must hold
        for (int k = 0; k < 10; k++) begin
            total++;
            if ({res_valid, res_acc, res_out, res_err} !== {1'b1, 40'd44, 16'd0, 1'b0}) begin
                bad++; $display("FAIL stall_hold[%0d] got=%b/%h/%h/%b exp=1/2c/0/0",
                                k, res_valid, res_acc, res_out, res_err);
            end
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        total++;
        if ({okc, oko, ina_cnt - i0, inb_cnt - j0, beat_cnt - b0} !== {2'b11, 32'd3, 32'd3, 32'd1}) begin
            bad++; $display("FAIL stall_counts got=%b%b ina=%0d inb=%0d beats=%0d exp=11 3 3 1",
                            okc, oko, ina_cnt - i0, inb_cnt - j0, beat_cnt - b0);
        end
        // immediately follow with another command; accumulator carries over
        send_cmd(8'd1, 2'b01, 3'd0, okc);
        send_op(32'd2, 32'd2, 0, oko);
        wait_res(100, ok, acc, out, err);
        total++;
        if ({okc, oko, ok, acc, err} !== {3'b111, 40'd48, 1'b0}) begin
            bad++; $display("FAIL back_to_back got=%b%b%b/%h/%b exp=111/30/0",
                            okc, oko, ok, acc, err);
        end
    endtask

    task automatic test_reset_in_wait;
        bit ok1, ok2; int s0, w0, n;
        do_reset();
        s0 = start_cnt;
        send_cmd(8'd1, 2'b01, 3'd0, ok1);
        send_op(32'd7, 32'd7, 0, ok2);
        n = 0;
        while (start_cnt == s0 && n < 50) begin @(negedge clk); n++; end
        total++;
        if ({ok1, ok2, start_cnt != s0, busy} !== 4'b1111) begin
            bad++; $display("FAIL rst_wait_setup got=%b exp=1111",
                            {ok1, ok2, start_cnt != s0, busy});
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({cmd_ready, busy, res_valid, mac_we, mac_addr, mac_wdata, res_acc, res_out, res_err}
            !== {1'b1, 100'h0}) begin
            bad++; $display("FAIL rst_wait_outputs rdy=%b busy=%b rv=%b we=%b addr=%h acc=%h exp=1/0/0/0/0/0",
                            cmd_ready, busy, res_valid, mac_we, mac_addr, res_acc);
        end
        reset = 1'b0;
        w0 = we_cnt;
        repeat (6) @(negedge clk);
        total++;
        if ({we_cnt - w0, cmd_ready} !== {32'd0, 1'b1}) begin
            bad++; $display("FAIL rst_wait_quiet writes=%0d rdy=%b exp=0/1", we_cnt - w0, cmd_ready);
        end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_mode = '0; cmd_shift = '0;
        op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0; irq_kill = 1'b0;
        test_reset();
        test_single();
        test_cumulative();
        test_hi_shift_and_len0();
        test_illegal_mode();
        test_timeout();
        test_back_to_back();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
